bp_sacc_dma_sequencer: RTL and testbench

DMA sequencer for the HE-encryption streaming accelerator. It takes a configured transfer (base address, length, target scratchpad), issues uncached 64-bit memory reads with a bounded number outstanding, and writes the in-order responses into one of the accelerator's scratchpads. It sits between the accelerator CSR block, which drives its config and start pulse and reads done/err, and the accelerator's outbound I/O command/response port and scratchpad write ports.

---
 rtl/bp_sacc_dma_sequencer_if.sv | 31 +++
 rtl/bp_sacc_dma_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_bp_sacc_dma_sequencer.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_sacc_dma_sequencer_if.sv
// Memory read command/response bundle between the DMA
// sequencer (master) and the accelerator I/O port (slave).
interface bp_sacc_dma_sequencer_if #(
  parameter int addr_width_p = 40,
  parameter int data_width_p = 64
);
  logic                    mem_req_v_o;
  logic [addr_width_p-1:0] mem_req_addr_o;
  logic                    mem_req_yumi_i;
  logic                    mem_resp_v_i;
  logic [data_width_p-1:0] mem_resp_data_i;
  logic                    mem_resp_ready_o;

  modport master (
    output mem_req_v_o,
    output mem_req_addr_o,
    output mem_resp_ready_o,
    input  mem_req_yumi_i,
    input  mem_resp_v_i,
    input  mem_resp_data_i
  );

  modport slave (
    input  mem_req_v_o,
    input  mem_req_addr_o,
    input  mem_resp_ready_o,
    output mem_req_yumi_i,
    output mem_resp_v_i,
    output mem_resp_data_i
  );
endinterface

// File: rtl/bp_sacc_dma_sequencer.sv
// DMA read sequencer: memory -> scratchpad, bounded outstanding.
// Optional abort_i input enabled by BP_SACC_DMA_SEQ_ABORT_EN.
module bp_sacc_dma_sequencer #(
  parameter int addr_width_p      = 40,
  parameter int data_width_p      = 64,
  parameter int spm_addr_width_p  = 12,
  parameter int num_spm_p         = 3,
  parameter int len_width_p       = 16,
  parameter int max_outstanding_p = 4
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        start_i,
  input  logic [1:0]                  spm_sel_i,
  input  logic [addr_width_p-1:0]     base_addr_i,
  input  logic [len_width_p-1:0]      length_i,
`ifdef BP_SACC_DMA_SEQ_ABORT_EN
  input  logic                        abort_i,
`endif
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o,
  bp_sacc_dma_sequencer_if.master     mem,
  output logic [num_spm_p-1:0]        spm_w_v_o,
  output logic [spm_addr_width_p-1:0] spm_w_addr_o,
  output logic [data_width_p-1:0]     spm_w_data_o
);

  localparam int OW = $clog2(max_outstanding_p) + 1;
  localparam int unsigned SpmDepth = 1 << spm_addr_width_p;
  localparam logic [num_spm_p-1:0] OneHot0 = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [1:0]                  r_sel;
  logic [addr_width_p-1:0]     r_base;
  logic [len_width_p-1:0]      r_len;
  logic [len_width_p-1:0]      r_issued;
  logic [len_width_p-1:0]      r_recvd;
  logic [OW-1:0]               r_outst;
  logic [OW-1:0]               w_outst_nxt;
  logic                        r_done;
  logic                        r_err;
  logic                        r_abort;
  logic [num_spm_p-1:0]        r_spm_v;
  logic [spm_addr_width_p-1:0] r_spm_addr;
  logic [data_width_p-1:0]     r_spm_data;

  logic w_start;
  logic w_cfg_bad;
  logic w_req_v;
  logic w_yumi;
  logic w_resp_hs;
  logic w_resp_ok;
  logic w_resp_spur;
  logic w_wr;
  logic w_last;
  logic w_abort_req;
  logic w_aborting;

`ifdef BP_SACC_DMA_SEQ_ABORT_EN
  assign w_abort_req = abort_i && (r_state == S_RUN);
`else
  assign w_abort_req = 1'b0;
`endif

  assign w_start   = start_i && (r_state == S_IDLE);
  assign w_cfg_bad = (int'(spm_sel_i) >= num_spm_p)
                  || (32'(length_i) > SpmDepth);

  assign w_req_v = (r_state == S_RUN) && !r_abort
                && (r_issued < r_len)
                && (r_outst < OW'(max_outstanding_p));

  assign w_yumi      = w_req_v && mem.mem_req_yumi_i;
  assign w_resp_hs   = (r_state == S_RUN) && mem.mem_resp_v_i;
  assign w_resp_ok   = w_resp_hs && (r_outst != '0);
  assign w_resp_spur = w_resp_hs && (r_outst == '0);
  assign w_aborting  = r_abort || w_abort_req;
  assign w_wr        = w_resp_ok && !w_aborting;
  assign w_last      = w_resp_ok && ((r_recvd + 1'b1) == r_len);

  assign mem.mem_req_v_o      = w_req_v;
  assign mem.mem_req_addr_o   = r_base
                              + addr_width_p'({r_issued, 3'b000});
  assign mem.mem_resp_ready_o = (r_state == S_RUN);

  assign busy_o       = (r_state != S_IDLE);
  assign done_o       = r_done;
  assign err_o        = r_err;
  assign spm_w_v_o    = r_spm_v;
  assign spm_w_addr_o = r_spm_addr;
  assign spm_w_data_o = r_spm_data;

  // In-flight count after this cycle's request/response handshakes
  always_comb begin
    w_outst_nxt = r_outst;
    unique case ({w_yumi, w_resp_ok})
      2'b10:   w_outst_nxt = r_outst + 1'b1;
      2'b01:   w_outst_nxt = r_outst - 1'b1;
      default: w_outst_nxt = r_outst;
    endcase
  end

  // Next-state decode for the IDLE/RUN/FIN sequencer
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_start && !w_cfg_bad) begin
          w_state_nxt = (length_i == '0) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        if (w_last || (w_aborting && (w_outst_nxt == '0))) begin
          w_state_nxt = S_FIN;
        end
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Transfer config, counters, flags and registered spm write
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_sel      <= '0;
      r_base     <= '0;
      r_len      <= '0;
      r_issued   <= '0;
      r_recvd    <= '0;
      r_outst    <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_abort    <= 1'b0;
      r_spm_v    <= '0;
      r_spm_addr <= '0;
      r_spm_data <= '0;
    end else begin
      r_spm_v <= '0;
      if (w_start) begin
        r_sel    <= spm_sel_i;
        r_base   <= base_addr_i;
        r_len    <= length_i;
        r_issued <= '0;
        r_recvd  <= '0;
        r_outst  <= '0;
        r_abort  <= 1'b0;
        r_done   <= w_cfg_bad;
        r_err    <= w_cfg_bad;
      end else begin
        r_outst <= w_outst_nxt;
        if (w_yumi) begin
          r_issued <= r_issued + 1'b1;
        end
        if (w_resp_ok) begin
          r_recvd <= r_recvd + 1'b1;
        end
        if (w_abort_req) begin
          r_abort <= 1'b1;
          r_err   <= 1'b1;
        end
        if (w_resp_spur) begin
          r_err <= 1'b1;
        end
        if (w_wr) begin
          r_spm_v    <= OneHot0 << r_sel;
          r_spm_addr <= r_recvd[spm_addr_width_p-1:0];
          r_spm_data <= mem.mem_resp_data_i;
        end
        if (r_state == S_FIN) begin
          r_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bp_sacc_dma_sequencer.sv
// Scoreboard bench for bp_sacc_dma_sequencer with a randomized
// in-order memory model and a high-level transfer reference.
module tb_bp_sacc_dma_sequencer;
  localparam int AW   = 40;
  localparam int DW   = 64;
  localparam int SAW  = 12;
  localparam int NSPM = 3;
  localparam int LW   = 16;
  localparam int MAXO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    sel = '0;
  logic [AW-1:0] base = '0;
  logic [LW-1:0] len = '0;
`ifdef BP_SACC_DMA_SEQ_ABORT_EN
  logic          abort = 1'b0;
`endif
  logic            busy;
  logic            done;
  logic            err;
  logic [NSPM-1:0] spm_v;
  logic [SAW-1:0]  spm_a;
  logic [DW-1:0]   spm_d;

  bp_sacc_dma_sequencer_if #(
    .addr_width_p(AW),
    .data_width_p(DW)
  ) mif ();

  bp_sacc_dma_sequencer #(
    .addr_width_p(AW),
    .data_width_p(DW),
    .spm_addr_width_p(SAW),
    .num_spm_p(NSPM),
    .len_width_p(LW),
    .max_outstanding_p(MAXO)
  ) dut (
    .clk_i(clk),
    .reset_n_i(rst_n),
    .start_i(start),
    .spm_sel_i(sel),
    .base_addr_i(base),
    .length_i(len),
`ifdef BP_SACC_DMA_SEQ_ABORT_EN
    .abort_i(abort),
`endif
    .busy_o(busy),
    .done_o(done),
    .err_o(err),
    .mem(mif),
    .spm_w_v_o(spm_v),
    .spm_w_addr_o(spm_a),
    .spm_w_data_o(spm_d)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NSPM-1:0] v;
    logic [SAW-1:0]  a;
    logic [DW-1:0]   d;
  } wr_t;

  typedef struct {
    longint        due;
    logic [DW-1:0] d;
  } pend_t;

  wr_t           exp_wr_q[$];
  logic [AW-1:0] exp_req_q[$];
  longint        hs_q[$];
  pend_t         pend[$];

  int     n_chk = 0;
  int     n_pass = 0;
  longint cyc = 0;
  int     n_wr = 0;
  int     n_acc = 0;
  longint last_hs = 0;

  int        yumi_pct = 100;
  int        resp_pct = 100;
  int        lat = 0;
  int        yumi_budget = 1 << 30;
  bit        spur_req = 0;
  bit        flush = 0;
  bit        abort_active = 0;
  logic [23:0] salt = '0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)",
                  name, act, exp, cyc);
  endtask

  function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
    return {salt, a};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // memory model: random yumi, in-order responses after latency
  initial begin
    mif.mem_req_yumi_i  = 1'b0;
    mif.mem_resp_v_i    = 1'b0;
    mif.mem_resp_data_i = '0;
    forever begin
      bit            y;
      bit            rv;
      bit            sp;
      logic [DW-1:0] rd;
      @(negedge clk);
      if (!rst_n || flush) begin
        pend.delete();
        flush = 0;
        mif.mem_req_yumi_i = 1'b0;
        mif.mem_resp_v_i   = 1'b0;
      end else begin
        if (pend.size() >= MAXO)
          chk("req_v_at_max", 64'(mif.mem_req_v_o), 0);
        y = mif.mem_req_v_o && (yumi_budget > 0) && !spur_req
            && ($urandom_range(99) < yumi_pct);
        sp = 0;
        rv = 0;
        rd = '0;
        if (spur_req && pend.size() == 0 && mif.mem_resp_ready_o) begin
          sp = 1;
          rv = 1;
          rd = 64'hBAD0_BAD0_BAD0_BAD0;
          spur_req = 0;
        end else if (pend.size() > 0 && cyc >= pend[0].due
                     && $urandom_range(99) < resp_pct) begin
          rv = 1;
          rd = pend[0].d;
        end
        mif.mem_req_yumi_i  = y;
        mif.mem_resp_v_i    = rv;
        mif.mem_resp_data_i = rd;
        if (rv && !sp && mif.mem_resp_ready_o) begin
          void'(pend.pop_front());
          last_hs = cyc + 1;
          if (!abort_active) hs_q.push_back(cyc + 1);
        end
        if (y) begin
          pend_t p;
          yumi_budget--;
          n_acc++;
          chk("req_expected", 64'(exp_req_q.size() != 0), 1);
          if (exp_req_q.size() != 0)
            chk("req_addr", 64'(mif.mem_req_addr_o),
                64'(exp_req_q.pop_front()));
          p.due = cyc + 1 + lat;
          p.d   = mdata(mif.mem_req_addr_o);
          pend.push_back(p);
        end
      end
    end
  end

  // write monitor: pops the scoreboard on every scratchpad write
  initial forever begin
    wr_t e;
    @(negedge clk);
    if (rst_n && spm_v != '0) begin
      n_wr++;
      chk("wr_expected", 64'(exp_wr_q.size() != 0), 1);
      if (exp_wr_q.size() != 0) begin
        e = exp_wr_q.pop_front();
        chk("wr_sel", 64'(spm_v), 64'(e.v));
        chk("wr_addr", 64'(spm_a), 64'(e.a));
        chk("wr_data", spm_d, e.d);
      end
      chk("wr_has_hs", 64'(hs_q.size() != 0), 1);
      if (hs_q.size() != 0)
        chk("wr_latency", 64'(cyc), 64'(hs_q.pop_front()));
    end
  end

  function automatic bit cfg_bad(input logic [1:0] s,
                                 input logic [LW-1:0] l);
    return (int'(s) >= NSPM) || (int'(l) > (1 << SAW));
  endfunction

  task automatic load_exp(input logic [1:0] s, input logic [AW-1:0] b,
                          input logic [LW-1:0] l);
    salt = 24'($urandom);
    if (!cfg_bad(s, l)) begin
      for (int i = 0; i < int'(l); i++) begin
        logic [AW-1:0] a;
        wr_t w;
        a = b + AW'(i * 8);
        exp_req_q.push_back(a);
        w.v = NSPM'(1) << s;
        w.a = SAW'(i);
        w.d = mdata(a);
        exp_wr_q.push_back(w);
      end
    end
  endtask

  task automatic pulse_start(input logic [1:0] s, input logic [AW-1:0] b,
                             input logic [LW-1:0] l);
    @(negedge clk);
    sel   = s;
    base  = b;
    len   = l;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int restart_at, output int t);
    t = 0;
    while (!done && t < 20000) begin
      if (t == restart_at) begin
        sel   = 2'd2;
        base  = 40'h12_3456_7800;
        len   = 16'd3;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      t++;
    end
    start = 1'b0;
  endtask

  task automatic run_xfer(input logic [1:0] s, input logic [AW-1:0] b,
                          input logic [LW-1:0] l, input bit extra_err,
                          input int restart_at);
    bit bad;
    int t;
    bad = cfg_bad(s, l);
    load_exp(s, b, l);
    pulse_start(s, b, l);
    wait_done(restart_at, t);
    chk("done_set", 64'(done), 1);
    chk("err_flag", 64'(err), 64'(bad || extra_err));
    chk("busy_clear", 64'(busy), 0);
    if (bad) begin
      chk("bad_cfg_latency", 64'(t), 0);
      chk("bad_cfg_no_req", 64'(mif.mem_req_v_o), 0);
    end else if (l != '0) begin
      chk("done_latency", 64'(cyc - last_hs), 1);
    end
    chk("req_remaining", 64'(exp_req_q.size()), 0);
    chk("wr_remaining", 64'(exp_wr_q.size()), 0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_req_v", 64'(mif.mem_req_v_o), 0);
    chk("rst_req_addr", 64'(mif.mem_req_addr_o), 0);
    chk("rst_resp_ready", 64'(mif.mem_resp_ready_o), 0);
    chk("rst_spm_v", 64'(spm_v), 0);
    chk("rst_spm_addr", 64'(spm_a), 0);
    chk("rst_spm_data", spm_d, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    lat = 0;
    run_xfer(2'd1, 40'h00_8000_0000, 16'd8, 0, -1);

    lat = 10;
    run_xfer(2'd2, 40'h01_2000_0100, 16'd16, 0, -1);
    lat = 0;

    run_xfer(2'd3, 40'h00_0000_1000, 16'd8, 0, -1);
    run_xfer(2'd0, 40'h00_0000_2000, 16'd0, 0, -1);
    run_xfer(2'd0, 40'h00_0000_3000, 16'd4097, 0, -1);
    run_xfer(2'd0, 40'h00_4000_0000, 16'd4096, 0, -1);

    run_xfer(2'd1, 40'h00_0000_5000, 16'd8, 0, 3);

    run_xfer(2'd2, 40'hFF_FFFF_FFF0, 16'd6, 0, -1);

    load_exp(2'd0, 40'h00_0000_6000, 16'd8);
    n_wr = 0;
    pulse_start(2'd0, 40'h00_0000_6000, 16'd8);
    t = 0;
    while (n_wr < 3 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("reset_test_writes", 64'(n_wr >= 3), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    exp_wr_q.delete();
    exp_req_q.delete();
    hs_q.delete();
    flush = 1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", 64'(busy), 0);
    chk("post_rst_req_v", 64'(mif.mem_req_v_o), 0);
    run_xfer(2'd2, 40'h00_0000_7000, 16'd8, 0, -1);

    spur_req = 1;
    run_xfer(2'd1, 40'h00_0000_8000, 16'd8, 1, -1);
    chk("spur_consumed", 64'(spur_req), 0);

    for (int k = 0; k < 8; k++) begin
      yumi_pct = $urandom_range(100, 40);
      resp_pct = $urandom_range(100, 40);
      lat      = $urandom_range(6, 0);
      run_xfer(2'($urandom_range(2, 0)), AW'({$urandom(), $urandom()}),
               LW'($urandom_range(40, 1)), 0, -1);
    end
    yumi_pct = 100;
    resp_pct = 100;
    lat      = 0;

`ifdef BP_SACC_DMA_SEQ_ABORT_EN
    abort = 1'b1;
    repeat (2) @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_err", 64'(err), 0);
    chk("idle_abort_done", 64'(done), 1);

    lat = 20;
    yumi_budget = 2;
    n_acc = 0;
    salt = 24'($urandom);
    exp_req_q.push_back(40'h00_0000_9000);
    exp_req_q.push_back(40'h00_0000_9008);
    pulse_start(2'd1, 40'h00_0000_9000, 16'd8);
    t = 0;
    while (n_acc < 2 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("abort_two_issued", 64'(n_acc), 2);
    @(negedge clk);
    abort_active = 1;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    yumi_budget = 1 << 30;
    wait_done(-1, t);
    chk("abort_done", 64'(done), 1);
    chk("abort_err", 64'(err), 1);
    chk("abort_req_remaining", 64'(exp_req_q.size()), 0);
    chk("abort_busy", 64'(busy), 0);
    abort_active = 0;
    lat = 0;
    run_xfer(2'd0, 40'h00_0000_A000, 16'd5, 0, -1);
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
